dest_reg_pipe: RTL and testbench

Destination-register tracking pipeline for the 32-bit MIPS core. It captures the 5-bit write-register number from the RegDst selection in EX and carries it, with its write enable, through the EX/MEM and MEM/WB boundaries. From this state it drives forwarding selects for the ALU operand muxes, a load-use stall request to fetch/decode, and the write address and enable for the register file.

---
 rtl/mips_pkg.sv | 12 +
 rtl/fwd_sel.sv | 28 ++
 rtl/dest_reg_pipe.sv | 117 +++++++++++
 tb/tb_dest_reg_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-number type and forwarding-select encodings.
package mips_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t  REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand; the MEM producer wins over the WB producer.
module fwd_sel
    import mips_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] mem_reg_i,
    input  logic             mem_wr_i,
    input  logic             mem_ld_i,
    input  logic [REG_W-1:0] wb_reg_i,
    input  logic             wb_wr_i,
    output logic [1:0]       sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (src_i != REG_W'(REG_ZERO)) begin
            // A load in MEM has no data yet; the load-use stall covers it.
            if (mem_wr_i && !mem_ld_i && (mem_reg_i == src_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_wr_i && (wb_reg_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/dest_reg_pipe.sv
// Carries the EX destination register through MEM and WB and derives forwarding,
// load-use stall and register-file write controls from it.
module dest_reg_pipe
    import mips_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] ExWriteReg,
    input  logic             ExRegWrite,
    input  logic             ExMemRead,
    input  logic             ExValid,
    input  logic [REG_W-1:0] ExRs,
    input  logic [REG_W-1:0] ExRt,
    input  logic [REG_W-1:0] IdRs,
    input  logic [REG_W-1:0] IdRt,
    input  logic             Stall,
    input  logic             Flush,
    output logic [REG_W-1:0] MemWriteReg,
    output logic             MemRegWrite,
    output logic             MemIsLoad,
    output logic [REG_W-1:0] WbWriteReg,
    output logic             WbRegWrite,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             LoadUseStall,
    output logic [CNT_W-1:0] LoadUseCount
);

    logic [REG_W-1:0] mem_reg_q, mem_reg_d, wb_reg_q, wb_reg_d;
    logic             mem_wr_q, mem_wr_d, mem_ld_q, mem_ld_d;
    logic             wb_wr_q, wb_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap;

    always_comb begin
        cap = ExValid && ExRegWrite && (ExWriteReg != REG_W'(REG_ZERO));
        LoadUseStall = cap && ExMemRead && ((ExWriteReg == IdRs) || (ExWriteReg == IdRt));

        mem_reg_d = mem_reg_q;
        mem_wr_d  = mem_wr_q;
        mem_ld_d  = mem_ld_q;
        wb_reg_d  = wb_reg_q;
        wb_wr_d   = wb_wr_q;
        cnt_d     = cnt_q;

        // An external stall freezes everything, including any pending flush.
        if (!Stall) begin
            wb_reg_d = mem_reg_q;
            wb_wr_d  = mem_wr_q;
            if (Flush) begin
                mem_reg_d = '0;
                mem_wr_d  = 1'b0;
                mem_ld_d  = 1'b0;
            end else begin
                mem_reg_d = ExWriteReg;
                mem_wr_d  = cap;
                mem_ld_d  = cap && ExMemRead;
            end
            if (LoadUseStall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mem_reg_q <= '0;
            mem_wr_q  <= 1'b0;
            mem_ld_q  <= 1'b0;
            wb_reg_q  <= '0;
            wb_wr_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mem_reg_q <= mem_reg_d;
            mem_wr_q  <= mem_wr_d;
            mem_ld_q  <= mem_ld_d;
            wb_reg_q  <= wb_reg_d;
            wb_wr_q   <= wb_wr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign MemWriteReg  = mem_reg_q;
    assign MemRegWrite  = mem_wr_q;
    assign MemIsLoad    = mem_ld_q;
    assign WbWriteReg   = wb_reg_q;
    assign WbRegWrite   = wb_wr_q;
    assign LoadUseCount = cnt_q;

    fwd_sel #(
        .REG_W (REG_W)
    ) u_fwd_a (
        .src_i     (ExRs),
        .mem_reg_i (mem_reg_q),
        .mem_wr_i  (mem_wr_q),
        .mem_ld_i  (mem_ld_q),
        .wb_reg_i  (wb_reg_q),
        .wb_wr_i   (wb_wr_q),
        .sel_o     (ForwardA)
    );

    fwd_sel #(
        .REG_W (REG_W)
    ) u_fwd_b (
        .src_i     (ExRt),
        .mem_reg_i (mem_reg_q),
        .mem_wr_i  (mem_wr_q),
        .mem_ld_i  (mem_ld_q),
        .wb_reg_i  (wb_reg_q),
        .wb_wr_i   (wb_wr_q),
        .sel_o     (ForwardB)
    );

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed and random checks of dest_reg_pipe against a queue-based pipeline model.
module tb_dest_reg_pipe;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [REG_W-1:0] ExWriteReg, ExRs, ExRt, IdRs, IdRt;
    logic             ExRegWrite, ExMemRead, ExValid, Stall, Flush;
    logic [REG_W-1:0] MemWriteReg, WbWriteReg;
    logic             MemRegWrite, MemIsLoad, WbRegWrite, LoadUseStall;
    logic [1:0]       ForwardA, ForwardB;
    logic [CNT_W-1:0] LoadUseCount;

    dest_reg_pipe #(
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .ExWriteReg   (ExWriteReg),
        .ExRegWrite   (ExRegWrite),
        .ExMemRead    (ExMemRead),
        .ExValid      (ExValid),
        .ExRs         (ExRs),
        .ExRt         (ExRt),
        .IdRs         (IdRs),
        .IdRt         (IdRt),
        .Stall        (Stall),
        .Flush        (Flush),
        .MemWriteReg  (MemWriteReg),
        .MemRegWrite  (MemRegWrite),
        .MemIsLoad    (MemIsLoad),
        .WbWriteReg   (WbWriteReg),
        .WbRegWrite   (WbRegWrite),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .LoadUseStall (LoadUseStall),
        .LoadUseCount (LoadUseCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } tag_t;

    // History of issued instructions: [0] is in WB, [1] is in MEM.
    tag_t        pipe[$];
    int unsigned nstall;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (pipe[1].wr && !pipe[1].ld && pipe[1].rd == src) return 2'b10;
        if (pipe[0].wr && pipe[0].rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit tracked();
        return ExValid && ExRegWrite && ExWriteReg != 5'd0;
    endfunction

    function automatic bit exp_lus();
        return tracked() && ExMemRead && (ExWriteReg == IdRs || ExWriteReg == IdRt);
    endfunction

    task automatic model_reset();
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        nstall = 0;
    endtask

    task automatic chk_all();
        #1;
        chk("mem_reg", 32'(MemWriteReg), 32'(pipe[1].rd));
        chk("mem_wr", 32'(MemRegWrite), 32'(pipe[1].wr));
        chk("mem_ld", 32'(MemIsLoad), 32'(pipe[1].ld));
        chk("wb_reg", 32'(WbWriteReg), 32'(pipe[0].rd));
        chk("wb_wr", 32'(WbRegWrite), 32'(pipe[0].wr));
        chk("fwd_a", 32'(ForwardA), 32'(exp_fwd(ExRs)));
        chk("fwd_b", 32'(ForwardB), 32'(exp_fwd(ExRt)));
        chk("lus", 32'(LoadUseStall), 32'(exp_lus()));
        chk("count", 32'(LoadUseCount), (nstall > 15) ? 32'd15 : 32'(nstall));
    endtask

    task automatic adv();
        tag_t e;
        bit   lus;
        lus = exp_lus();
        e   = Flush ? tag_t'('0) : tag_t'({ExWriteReg, tracked(), tracked() && ExMemRead});
        @(posedge Clk);
        if (!Stall) begin
            pipe.push_back(e);
            void'(pipe.pop_front());
            if (lus) nstall++;
        end
        @(negedge Clk);
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [4:0] rs, input logic [4:0] rt);
        ExValid = 1'b1; ExWriteReg = rd; ExRegWrite = wr; ExMemRead = ld;
        ExRs = rs; ExRt = rt;
    endtask

    initial begin
        Rst = 1'b1; Stall = 0; Flush = 0; IdRs = 0; IdRt = 0;
        issue(5'd0, 0, 0, 5'd0, 5'd0);
        ExValid = 0;
        model_reset();
        chk_all();
        @(negedge Clk);
        Rst = 1'b0;

        // Load-use: load to r9 with ID reading r9
        issue(5'd9, 1, 1, 5'd1, 5'd2); IdRt = 5'd9;
        chk_all();
        chk("lu_stall", 32'(LoadUseStall), 32'd1);
        chk("lu_cnt0", 32'(LoadUseCount), 32'd0);
        adv();
        IdRt = 5'd0;
        issue(5'd3, 1, 0, 5'd9, 5'd0);
        chk_all();
        chk("lu_cnt1", 32'(LoadUseCount), 32'd1);
        chk("lu_nofwd", 32'(ForwardA), 32'd0);
        adv();

        // Basic forward: ALU op to r8, then consumers
        issue(5'd8, 1, 0, 5'd0, 5'd0);
        chk_all(); adv();
        issue(5'd2, 1, 0, 5'd8, 5'd0);
        chk_all();
        chk("fwd_mem_a", 32'(ForwardA), 32'h2);
        adv();
        issue(5'd6, 1, 0, 5'd0, 5'd8);
        chk_all();
        chk("fwd_wb_b", 32'(ForwardB), 32'h1);
        chk("wb_r8", 32'(WbWriteReg), 32'd8);
        chk("wb_we", 32'(WbRegWrite), 32'd1);
        adv();

        // $0 is never tracked
        issue(5'd0, 1, 0, 5'd0, 5'd0);
        chk_all(); adv();
        chk_all();
        chk("zero_wr", 32'(MemRegWrite), 32'd0);
        chk("zero_fwd", 32'(ForwardA), 32'd0);

        // Same register in MEM and WB: MEM wins
        issue(5'd5, 1, 0, 5'd0, 5'd0);
        adv();
        issue(5'd5, 1, 0, 5'd0, 5'd0);
        adv();
        issue(5'd1, 1, 0, 5'd5, 5'd5);
        chk_all();
        chk("prio_a", 32'(ForwardA), 32'h2);
        chk("prio_b", 32'(ForwardB), 32'h2);

        // Stall with r12 in MEM; flush held until release
        issue(5'd12, 1, 0, 5'd0, 5'd0);
        adv();
        issue(5'd13, 1, 0, 5'd0, 5'd0);
        Stall = 1; Flush = 1;
        for (int i = 0; i < 3; i++) begin
            chk_all();
            chk("stall_hold", 32'(MemWriteReg), 32'd12);
            adv();
        end
        Stall = 0;
        adv();
        Flush = 0;
        chk_all();
        chk("flush_mem", 32'(MemWriteReg), 32'd0);
        chk("flush_memwr", 32'(MemRegWrite), 32'd0);
        chk("flush_wb", 32'(WbWriteReg), 32'd12);

        // Reset mid-flight with r4 in WB and r7 in MEM
        issue(5'd4, 1, 0, 5'd0, 5'd0);
        adv();
        issue(5'd7, 1, 0, 5'd0, 5'd0);
        adv();
        issue(5'd1, 1, 0, 5'd7, 5'd4);
        chk_all();
        #2 Rst = 1'b1;
        model_reset();
        chk_all();
        chk("rst_mem", 32'(MemWriteReg), 32'd0);
        chk("rst_wb", 32'(WbWriteReg), 32'd0);
        chk("rst_fwd", 32'({ForwardA, ForwardB}), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // Counter saturation
        issue(5'd3, 1, 1, 5'd0, 5'd0); IdRs = 5'd3;
        for (int i = 0; i < 20; i++) adv();
        chk_all();
        chk("cnt_sat", 32'(LoadUseCount), 32'd15);
        IdRs = 0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            ExValid    = ($urandom_range(0, 7) != 0);
            ExRegWrite = ($urandom_range(0, 3) != 0);
            ExMemRead  = ($urandom_range(0, 2) == 0);
            ExWriteReg = 5'($urandom_range(0, 7));
            ExRs       = 5'($urandom_range(0, 7));
            ExRt       = 5'($urandom_range(0, 7));
            IdRs       = 5'($urandom_range(0, 7));
            IdRt       = 5'($urandom_range(0, 7));
            Stall      = ($urandom_range(0, 7) == 0);
            Flush      = ($urandom_range(0, 7) == 0);
            chk_all();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
